dual_issue_steer_unit: RTL

- Registered successor to the combinational dual-issue hazard logic. Sits between decode and the two execute lanes.
- Lane 0 is ALU+branch. Lane 1 is ALU+memory.
- Per cycle it accepts an in-order instruction pair, resolves load-use hazards with a per-register busy scoreboard, and splits dependent or structurally conflicting pairs through a one-entry replay buffer.
- It steers each instruction to the legal lane and drives registered lane outputs. The pipeline stall/flush masks are derived from in_ready.

---
 rtl/dual_issue_steer_unit.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/dual_issue_steer_unit.sv
// Dual-issue steering stage: load-use scoreboard, pair splitting through a
// one-entry replay buffer, and lane steering with registered lane outputs.
module dual_issue_steer_unit #(
  parameter int INST_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int ID_WIDTH     = 8,
  parameter int REG_BITS     = 5,
  parameter int LOAD_LATENCY = 2,
  parameter int STAT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INST_WIDTH-1:0] s0_inst,
  input  logic [ADDR_WIDTH-1:0] s0_pc,
  input  logic [ID_WIDTH-1:0]   s0_id,
  input  logic [1:0]            s0_class,
  input  logic [1:0]            s0_src_mask,
  input  logic [REG_BITS-1:0]   s0_rs,
  input  logic [REG_BITS-1:0]   s0_rt,
  input  logic [REG_BITS-1:0]   s0_dst,
  input  logic                  s0_dst_en,
  input  logic                  s0_is_load,
  input  logic [INST_WIDTH-1:0] s1_inst,
  input  logic [ADDR_WIDTH-1:0] s1_pc,
  input  logic [ID_WIDTH-1:0]   s1_id,
  input  logic [1:0]            s1_class,
  input  logic [1:0]            s1_src_mask,
  input  logic [REG_BITS-1:0]   s1_rs,
  input  logic [REG_BITS-1:0]   s1_rt,
  input  logic [REG_BITS-1:0]   s1_dst,
  input  logic                  s1_dst_en,
  input  logic                  s1_is_load,
  output logic                  lane0_valid,
  output logic [INST_WIDTH-1:0] lane0_inst,
  output logic [ADDR_WIDTH-1:0] lane0_pc,
  output logic [ID_WIDTH-1:0]   lane0_id,
  output logic                  lane1_valid,
  output logic [INST_WIDTH-1:0] lane1_inst,
  output logic [ADDR_WIDTH-1:0] lane1_pc,
  output logic [ID_WIDTH-1:0]   lane1_id,
  output logic [STAT_WIDTH-1:0] stall_cycles
);

  localparam int         NUM_REGS = 1 << REG_BITS;
  localparam logic [2:0] LAT      = 3'(LOAD_LATENCY);
  localparam logic [1:0] CLS_MEM  = 2'd1;
  localparam logic [1:0] CLS_BR   = 2'd2;
  localparam logic [1:0] CLS_NOP  = 2'd3;

  typedef struct packed {
    logic [INST_WIDTH-1:0] inst;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ID_WIDTH-1:0]   id;
    logic [1:0]            cls;
    logic [1:0]            src_mask;
    logic [REG_BITS-1:0]   rs;
    logic [REG_BITS-1:0]   rt;
    logic [REG_BITS-1:0]   dst;
    logic                  dst_en;
    logic                  is_load;
  } slot_t;

  typedef enum logic {ST_EMPTY = 1'b0, ST_HOLD = 1'b1} state_t;

  state_t                state_reg, state_next;
  slot_t                 slot0, slot1, buf_reg, buf_next, iss_a, iss_b;
  slot_t                 lane0_slot_next, lane1_slot_next;
  logic                  iss_a_valid, iss_b_valid;
  logic                  lane0_valid_next, lane1_valid_next;
  logic [NUM_REGS-1:0]   busy_vec;
  logic                  s0_lu, s1_lu, buf_lu;
  logic                  pair_active, raw_hz, waw_hz, struct_hz, split;
  logic [STAT_WIDTH-1:0] stall_cnt_reg;

  // True when a non-NOP instruction reads a register that is still busy.
  function automatic logic reads_busy(input slot_t s, input logic [NUM_REGS-1:0] bv);
    reads_busy = (s.cls != CLS_NOP) &&
                 ((s.src_mask[0] && bv[s.rs]) || (s.src_mask[1] && bv[s.rt]));
  endfunction

  // True when s is a load that will write register r.
  function automatic logic loads_reg(input slot_t s, input logic [REG_BITS-1:0] r);
    loads_reg = (s.cls != CLS_NOP) && s.is_load && s.dst_en && (s.dst == r);
  endfunction

  // Bundle slot 0 inputs.
  always_comb begin
    slot0          = '0;
    slot0.inst     = s0_inst;
    slot0.pc       = s0_pc;
    slot0.id       = s0_id;
    slot0.cls      = s0_class;
    slot0.src_mask = s0_src_mask;
    slot0.rs       = s0_rs;
    slot0.rt       = s0_rt;
    slot0.dst      = s0_dst;
    slot0.dst_en   = s0_dst_en;
    slot0.is_load  = s0_is_load;
  end

  // Bundle slot 1 inputs.
  always_comb begin
    slot1          = '0;
    slot1.inst     = s1_inst;
    slot1.pc       = s1_pc;
    slot1.id       = s1_id;
    slot1.cls      = s1_class;
    slot1.src_mask = s1_src_mask;
    slot1.rs       = s1_rs;
    slot1.rt       = s1_rt;
    slot1.dst      = s1_dst;
    slot1.dst_en   = s1_dst_en;
    slot1.is_load  = s1_is_load;
  end

  // Per-register load scoreboard; r0 never busy, reload wins over decrement.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_sb
      logic [2:0] cnt_reg;
      logic       reload;
      assign reload = (gi != 0) &&
                      ((iss_a_valid && loads_reg(iss_a, REG_BITS'(gi))) ||
                       (iss_b_valid && loads_reg(iss_b, REG_BITS'(gi))));
      assign busy_vec[gi] = (gi != 0) && (cnt_reg != 3'd0);
      // Load latency on issue of a load, otherwise count down to idle.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)               cnt_reg <= 3'd0;
        else if (reload)            cnt_reg <= LAT;
        else if (cnt_reg != 3'd0)   cnt_reg <= cnt_reg - 3'd1;
      end
    end
  endgenerate

  assign s0_lu       = reads_busy(slot0, busy_vec);
  assign s1_lu       = reads_busy(slot1, busy_vec);
  assign buf_lu      = reads_busy(buf_reg, busy_vec);
  assign pair_active = (slot0.cls != CLS_NOP) && (slot1.cls != CLS_NOP);
  assign raw_hz      = pair_active && slot0.dst_en && (slot0.dst != '0) &&
                       ((slot1.src_mask[0] && (slot1.rs == slot0.dst)) ||
                        (slot1.src_mask[1] && (slot1.rt == slot0.dst)));
  assign waw_hz      = pair_active && slot0.dst_en && slot1.dst_en && (slot0.dst == slot1.dst);
  assign struct_hz   = ((slot0.cls == CLS_MEM) && (slot1.cls == CLS_MEM)) ||
                       ((slot0.cls == CLS_BR)  && (slot1.cls == CLS_BR));
  assign split       = raw_hz || waw_hz || struct_hz || s1_lu;

  // Issue decision: hold on slot0 load-use, split into the buffer, or dual issue.
  always_comb begin
    state_next  = state_reg;
    buf_next    = buf_reg;
    in_ready    = 1'b0;
    iss_a       = slot0;
    iss_b       = slot1;
    iss_a_valid = 1'b0;
    iss_b_valid = 1'b0;
    case (state_reg)
      ST_EMPTY: begin
        in_ready = !(in_valid && s0_lu);
        if (in_valid && !s0_lu) begin
          iss_a_valid = 1'b1;
          if (split) begin
            buf_next   = slot1;
            state_next = ST_HOLD;
          end else begin
            iss_b_valid = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        iss_a = buf_reg;
        if (!buf_lu) begin
          iss_a_valid = 1'b1;
          state_next  = ST_EMPTY;
        end
      end
      default: state_next = ST_EMPTY;
    endcase
    // A mispredict squashes everything issuing this cycle; the scoreboard stays.
    if (flush) begin
      state_next  = ST_EMPTY;
      buf_next    = '0;
      iss_a_valid = 1'b0;
      iss_b_valid = 1'b0;
    end
  end

  // Lane steering: memory to lane 1, branch to lane 0, else program order.
  always_comb begin
    lane0_valid_next = 1'b0;
    lane1_valid_next = 1'b0;
    lane0_slot_next  = '0;
    lane1_slot_next  = '0;
    if (iss_a_valid && iss_b_valid) begin
      lane0_valid_next = 1'b1;
      lane1_valid_next = 1'b1;
      if ((iss_a.cls == CLS_MEM) || (iss_b.cls == CLS_BR)) begin
        lane0_slot_next = iss_b;
        lane1_slot_next = iss_a;
      end else begin
        lane0_slot_next = iss_a;
        lane1_slot_next = iss_b;
      end
    end else if (iss_a_valid) begin
      if (iss_a.cls == CLS_MEM) begin
        lane1_valid_next = 1'b1;
        lane1_slot_next  = iss_a;
      end else begin
        lane0_valid_next = 1'b1;
        lane0_slot_next  = iss_a;
      end
    end
  end

  // State, replay buffer and registered lane outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= ST_EMPTY;
      buf_reg     <= '0;
      lane0_valid <= 1'b0;
      lane0_inst  <= '0;
      lane0_pc    <= '0;
      lane0_id    <= '0;
      lane1_valid <= 1'b0;
      lane1_inst  <= '0;
      lane1_pc    <= '0;
      lane1_id    <= '0;
    end else begin
      state_reg   <= state_next;
      buf_reg     <= buf_next;
      lane0_valid <= lane0_valid_next;
      lane0_inst  <= lane0_slot_next.inst;
      lane0_pc    <= lane0_slot_next.pc;
      lane0_id    <= lane0_slot_next.id;
      lane1_valid <= lane1_valid_next;
      lane1_inst  <= lane1_slot_next.inst;
      lane1_pc    <= lane1_slot_next.pc;
      lane1_id    <= lane1_slot_next.id;
    end
  end

  // Saturating count of cycles where decode offered a pair and was refused.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      stall_cnt_reg <= '0;
    else if (in_valid && !in_ready && (stall_cnt_reg != '1))
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
  end

  assign stall_cycles = stall_cnt_reg;

endmodule
